// File: rtl/llc_ctrl_regs_pkg.sv
// Shared types and default geometry for the LLC control-register bank.
package llc_ctrl_regs_pkg;

    localparam int SET_BITS_DEF = 10;
    localparam int TAG_BITS_DEF = 16;
    localparam int WAYS_DEF     = 16;
    localparam int WAY_BITS_DEF = $clog2(WAYS_DEF);

    typedef logic [SET_BITS_DEF-1:0]              llc_set_t;
    typedef logic [TAG_BITS_DEF-1:0]              llc_tag_t;
    typedef logic [WAY_BITS_DEF-1:0]              llc_way_t;
    typedef logic [SET_BITS_DEF+TAG_BITS_DEF-1:0] line_addr_t;

    typedef struct packed {
        llc_set_t set;
        llc_tag_t tag;
    } stall_entry_t;

    // Pointer width for a FIFO, never zero even for degenerate depths.
    function automatic int ptr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/llc_ctrl_regs_stall_fifo.sv
// Stalled-request FIFO with per-entry valid bits; set-conflict match is
// built only when LLC_STALL_MATCH_EN is defined.
module llc_stall_fifo
    import llc_ctrl_regs_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int SET_BITS = SET_BITS_DEF,
    parameter int TAG_BITS = TAG_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                soft_rst,
    input  logic                push,
    input  logic                pop,
    input  logic [SET_BITS-1:0] set_in,
    input  logic [TAG_BITS-1:0] tag_in,
    input  logic [SET_BITS-1:0] lookup_set,
    output logic [SET_BITS-1:0] head_set,
    output logic [TAG_BITS-1:0] head_tag,
    output logic                empty,
    output logic                full,
    output logic                hit
);

    localparam int PW = ptr_bits(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [SET_BITS-1:0] set_mem_q [DEPTH];
    logic [SET_BITS-1:0] set_mem_d [DEPTH];
    logic [TAG_BITS-1:0] tag_mem_q [DEPTH];
    logic [TAG_BITS-1:0] tag_mem_d [DEPTH];
    logic [DEPTH-1:0]    valid_q, valid_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                push_ok, pop_ok;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(DEPTH));

    // A push into a full FIFO is accepted only when a pop frees the head slot.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        set_mem_d = set_mem_q;
        tag_mem_d = tag_mem_q;
        valid_d   = valid_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        if (soft_rst) begin
            valid_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (pop_ok) begin
                valid_d[rd_ptr_q] = 1'b0;
                rd_ptr_d          = rd_ptr_q + PW'(1);
            end
            // Push after pop so a full push+pop on the same slot leaves it valid.
            if (push_ok) begin
                valid_d[wr_ptr_q]   = 1'b1;
                set_mem_d[wr_ptr_q] = set_in;
                tag_mem_d[wr_ptr_q] = tag_in;
                wr_ptr_d            = wr_ptr_q + PW'(1);
            end
            if (push_ok && !pop_ok) begin
                cnt_d = cnt_q + CW'(1);
            end else if (pop_ok && !push_ok) begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                set_mem_q[i] <= '0;
                tag_mem_q[i] <= '0;
            end
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            set_mem_q <= set_mem_d;
            tag_mem_q <= tag_mem_d;
            valid_q   <= valid_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign head_set = valid_q[rd_ptr_q] ? set_mem_q[rd_ptr_q] : '0;
    assign head_tag = valid_q[rd_ptr_q] ? tag_mem_q[rd_ptr_q] : '0;

`ifdef LLC_STALL_MATCH_EN
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (set_mem_q[i] == lookup_set)) begin
                hit = 1'b1;
            end
        end
    end
`else
    logic unused_lookup;
    assign unused_lookup = &{1'b0, lookup_set};
    assign hit           = 1'b0;
`endif

endmodule

// File: rtl/llc_ctrl_regs.sv
// LLC control-register bank: flags, sweep counter, DMA counter, stall FIFO
// and eviction address. Define LLC_STALL_MATCH_EN to enable stall_hit.
module llc_ctrl_regs
    import llc_ctrl_regs_pkg::*;
#(
    parameter int NUM_FLAGS   = 8,
    parameter int SET_BITS    = SET_BITS_DEF,
    parameter int TAG_BITS    = TAG_BITS_DEF,
    parameter int WAYS        = WAYS_DEF,
    parameter int STALL_DEPTH = 4,
    parameter int BURST_BITS  = 8,
    localparam int WAY_BITS   = $clog2(WAYS),
    localparam int AW         = SET_BITS + TAG_BITS
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               rst_state,
    input  logic [NUM_FLAGS-1:0]               flag_set,
    input  logic [NUM_FLAGS-1:0]               flag_clr,
    output logic [NUM_FLAGS-1:0]               flags,
    input  logic                               clr_rst_stall,
    output logic                               rst_stall,
    input  logic                               sweep_clr,
    input  logic                               sweep_incr,
    output logic [SET_BITS-1:0]                sweep_set,
    output logic                               sweep_done,
    input  logic                               dma_load,
    input  logic [AW-1:0]                      dma_addr_in,
    input  logic [BURST_BITS-1:0]              dma_len_in,
    input  logic                               dma_incr,
    output logic [AW-1:0]                      dma_addr,
    output logic                               dma_last,
    input  logic                               stall_push,
    input  logic                               stall_pop,
    input  logic [SET_BITS-1:0]                stall_set_in,
    input  logic [TAG_BITS-1:0]                stall_tag_in,
    output logic [SET_BITS-1:0]                stall_set,
    output logic [TAG_BITS-1:0]                stall_tag,
    output logic                               stall_empty,
    output logic                               stall_full,
    input  logic [SET_BITS-1:0]                lookup_set,
    output logic                               stall_hit,
    input  logic                               lookup_en,
    input  logic [WAY_BITS-1:0]                way_next,
    input  logic [WAYS-1:0][TAG_BITS-1:0]      tags_buf,
    input  logic [SET_BITS-1:0]                cur_set,
    output logic [AW-1:0]                      addr_evict
);

    logic [NUM_FLAGS-1:0]  flags_q, flags_d;
    logic                  rst_stall_q, rst_stall_d;
    logic [SET_BITS-1:0]   sweep_set_q, sweep_set_d;
    logic                  sweep_done_q, sweep_done_d;
    logic [AW-1:0]         dma_addr_q, dma_addr_d;
    logic [BURST_BITS-1:0] dma_rem_q, dma_rem_d;
    logic [AW-1:0]         addr_evict_q, addr_evict_d;

    always_comb begin
        flags_d      = (flags_q | flag_set) & ~flag_clr;
        rst_stall_d  = rst_stall_q && !clr_rst_stall;
        sweep_set_d  = sweep_set_q;
        sweep_done_d = 1'b0;
        dma_addr_d   = dma_addr_q;
        dma_rem_d    = dma_rem_q;
        addr_evict_d = lookup_en ? {tags_buf[way_next], cur_set} : addr_evict_q;

        if (sweep_clr) begin
            sweep_set_d = '0;
        end else if (sweep_incr) begin
            sweep_set_d  = sweep_set_q + SET_BITS'(1);
            sweep_done_d = &sweep_set_q;
        end

        // A zero-length burst still covers the line being loaded.
        if (dma_load) begin
            dma_addr_d = dma_addr_in;
            dma_rem_d  = (dma_len_in == '0) ? BURST_BITS'(1) : dma_len_in;
        end else if (dma_incr) begin
            dma_addr_d = dma_addr_q + AW'(1);
            if (dma_rem_q != '0) begin
                dma_rem_d = dma_rem_q - BURST_BITS'(1);
            end
        end

        // Soft reset matches hard reset except that the eviction address holds.
        if (rst_state) begin
            flags_d      = '0;
            rst_stall_d  = 1'b1;
            sweep_set_d  = '0;
            sweep_done_d = 1'b0;
            dma_addr_d   = '0;
            dma_rem_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flags_q      <= '0;
            rst_stall_q  <= 1'b1;
            sweep_set_q  <= '0;
            sweep_done_q <= 1'b0;
            dma_addr_q   <= '0;
            dma_rem_q    <= '0;
            addr_evict_q <= '0;
        end else begin
            flags_q      <= flags_d;
            rst_stall_q  <= rst_stall_d;
            sweep_set_q  <= sweep_set_d;
            sweep_done_q <= sweep_done_d;
            dma_addr_q   <= dma_addr_d;
            dma_rem_q    <= dma_rem_d;
            addr_evict_q <= addr_evict_d;
        end
    end

    assign flags      = flags_q;
    assign rst_stall  = rst_stall_q;
    assign sweep_set  = sweep_set_q;
    assign sweep_done = sweep_done_q;
    assign dma_addr   = dma_addr_q;
    assign dma_last   = (dma_rem_q == BURST_BITS'(1));
    assign addr_evict = addr_evict_q;

    llc_stall_fifo #(
        .DEPTH    (STALL_DEPTH),
        .SET_BITS (SET_BITS),
        .TAG_BITS (TAG_BITS)
    ) u_stall_fifo (
        .clk        (clk),
        .rst        (rst),
        .soft_rst   (rst_state),
        .push       (stall_push),
        .pop        (stall_pop),
        .set_in     (stall_set_in),
        .tag_in     (stall_tag_in),
        .lookup_set (lookup_set),
        .head_set   (stall_set),
        .head_tag   (stall_tag),
        .empty      (stall_empty),
        .full       (stall_full),
        .hit        (stall_hit)
    );

endmodule

// File: tb/tb_llc_ctrl_regs.sv
// Directed self-checking bench for llc_ctrl_regs (default parameters).
module tb_llc_ctrl_regs;

    localparam int NF = 8;
    localparam int SB = 10;
    localparam int TB = 16;
    localparam int WY = 16;
    localparam int WB = 4;
    localparam int AW = SB + TB;
    localparam int BB = 8;

`ifdef LLC_STALL_MATCH_EN
    localparam logic HIT_ON = 1'b1;
`else
    localparam logic HIT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, rst_state;
    logic [NF-1:0] flag_set, flag_clr, flags;
    logic clr_rst_stall, rst_stall;
    logic sweep_clr, sweep_incr, sweep_done;
    logic [SB-1:0] sweep_set;
    logic dma_load, dma_incr, dma_last;
    logic [AW-1:0] dma_addr_in, dma_addr;
    logic [BB-1:0] dma_len_in;
    logic stall_push, stall_pop, stall_empty, stall_full, stall_hit;
    logic [SB-1:0] stall_set_in, stall_set, lookup_set, cur_set;
    logic [TB-1:0] stall_tag_in, stall_tag;
    logic lookup_en;
    logic [WB-1:0] way_next;
    logic [WY-1:0][TB-1:0] tags_buf;
    logic [AW-1:0] addr_evict;

    int n_cmp = 0;
    int n_err = 0;
    int pulses;

    typedef struct {
        logic [NF-1:0] set;
        logic [NF-1:0] clr;
        logic [NF-1:0] exp;
    } flag_vec_t;
    flag_vec_t fv [7];

    always #5 clk = ~clk;

    llc_ctrl_regs dut (
        .clk(clk), .rst(rst), .rst_state(rst_state),
        .flag_set(flag_set), .flag_clr(flag_clr), .flags(flags),
        .clr_rst_stall(clr_rst_stall), .rst_stall(rst_stall),
        .sweep_clr(sweep_clr), .sweep_incr(sweep_incr),
        .sweep_set(sweep_set), .sweep_done(sweep_done),
        .dma_load(dma_load), .dma_addr_in(dma_addr_in), .dma_len_in(dma_len_in),
        .dma_incr(dma_incr), .dma_addr(dma_addr), .dma_last(dma_last),
        .stall_push(stall_push), .stall_pop(stall_pop),
        .stall_set_in(stall_set_in), .stall_tag_in(stall_tag_in),
        .stall_set(stall_set), .stall_tag(stall_tag),
        .stall_empty(stall_empty), .stall_full(stall_full),
        .lookup_set(lookup_set), .stall_hit(stall_hit),
        .lookup_en(lookup_en), .way_next(way_next), .tags_buf(tags_buf),
        .cur_set(cur_set), .addr_evict(addr_evict)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pop(input logic pu, input logic po, input logic [SB-1:0] s, input logic [TB-1:0] t);
        stall_push = pu; stall_pop = po; stall_set_in = s; stall_tag_in = t;
        step();
        stall_push = 1'b0; stall_pop = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " flags"}, 64'(flags), 64'h0);
        check({tag, " rst_stall"}, 64'(rst_stall), 64'h1);
        check({tag, " sweep_set"}, 64'(sweep_set), 64'h0);
        check({tag, " sweep_done"}, 64'(sweep_done), 64'h0);
        check({tag, " dma_addr"}, 64'(dma_addr), 64'h0);
        check({tag, " dma_last"}, 64'(dma_last), 64'h0);
        check({tag, " stall_empty"}, 64'(stall_empty), 64'h1);
        check({tag, " stall_full"}, 64'(stall_full), 64'h0);
        check({tag, " stall_set"}, 64'(stall_set), 64'h0);
        check({tag, " stall_tag"}, 64'(stall_tag), 64'h0);
        check({tag, " stall_hit"}, 64'(stall_hit), 64'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, expected test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; rst_state = 1'b0;
        flag_set = '0; flag_clr = '0; clr_rst_stall = 1'b0;
        sweep_clr = 1'b0; sweep_incr = 1'b0;
        dma_load = 1'b0; dma_addr_in = '0; dma_len_in = '0; dma_incr = 1'b0;
        stall_push = 1'b0; stall_pop = 1'b0; stall_set_in = '0; stall_tag_in = '0;
        lookup_set = '0; lookup_en = 1'b0; way_next = '0; cur_set = '0;
        for (int i = 0; i < WY; i++) tags_buf[i] = TB'(16'h1000 + i);

        fv[0] = '{8'h05, 8'h00, 8'h05};
        fv[1] = '{8'h01, 8'h05, 8'h00};
        fv[2] = '{8'hF0, 8'h00, 8'hF0};
        fv[3] = '{8'h00, 8'h30, 8'hC0};
        fv[4] = '{8'h0C, 8'h0C, 8'hC0};
        fv[5] = '{8'h00, 8'h00, 8'hC0};
        fv[6] = '{8'hFF, 8'h00, 8'hFF};

        step(); step();
        check_reset_state("hard_rst");
        check("hard_rst addr_evict", 64'(addr_evict), 64'h0);
        rst = 1'b1;
        step();
        check_reset_state("post_rst");

        for (int i = 0; i < 7; i++) begin
            flag_set = fv[i].set; flag_clr = fv[i].clr;
            step();
            check($sformatf("flags vec%0d", i), 64'(flags), 64'(fv[i].exp));
        end
        flag_set = '0; flag_clr = '0;

        clr_rst_stall = 1'b1; step();
        check("rst_stall cleared", 64'(rst_stall), 64'h0);
        clr_rst_stall = 1'b0; step();
        check("rst_stall stays low", 64'(rst_stall), 64'h0);

        sweep_incr = 1'b1;
        pulses = 0;
        for (int i = 0; i < 1023; i++) begin
            step();
            if (sweep_done) pulses++;
        end
        check("sweep_set 1023", 64'(sweep_set), 64'h3FF);
        check("sweep_done early pulses", 64'(pulses), 64'h0);
        step();
        check("sweep wrap", 64'(sweep_set), 64'h0);
        check("sweep_done pulse", 64'(sweep_done), 64'h1);
        sweep_incr = 1'b0; step();
        check("sweep_done one cycle", 64'(sweep_done), 64'h0);
        sweep_incr = 1'b1; step(); step(); step();
        check("sweep_set 3", 64'(sweep_set), 64'h3);
        sweep_clr = 1'b1; step();
        check("sweep_clr beats incr", 64'(sweep_set), 64'h0);
        sweep_clr = 1'b0; sweep_incr = 1'b0;

        dma_load = 1'b1; dma_addr_in = 26'h3FFFFFF; dma_len_in = 8'd3; step();
        dma_load = 1'b0;
        check("dma load addr", 64'(dma_addr), 64'h3FFFFFF);
        check("dma load last", 64'(dma_last), 64'h0);
        dma_incr = 1'b1; step();
        check("dma incr1 addr", 64'(dma_addr), 64'h0);
        check("dma incr1 last", 64'(dma_last), 64'h0);
        step();
        check("dma incr2 addr", 64'(dma_addr), 64'h1);
        check("dma incr2 last", 64'(dma_last), 64'h1);
        step();
        check("dma incr3 addr", 64'(dma_addr), 64'h2);
        check("dma incr3 last", 64'(dma_last), 64'h0);
        step();
        check("dma rem0 addr", 64'(dma_addr), 64'h3);
        check("dma rem0 last", 64'(dma_last), 64'h0);
        dma_load = 1'b1; dma_addr_in = 26'h0123456; dma_len_in = 8'd0; step();
        dma_load = 1'b0; dma_incr = 1'b0;
        check("dma len0 addr", 64'(dma_addr), 64'h0123456);
        check("dma len0 last", 64'(dma_last), 64'h1);

        for (int i = 1; i <= 4; i++) push_pop(1'b1, 1'b0, SB'(i), TB'(16'h100 + i));
        check("fifo full", 64'(stall_full), 64'h1);
        check("fifo head1 set", 64'(stall_set), 64'h1);
        check("fifo head1 tag", 64'(stall_tag), 64'h101);
        lookup_set = 10'd3; #1;
        check("hit set3", 64'(stall_hit), 64'(HIT_ON));
        push_pop(1'b1, 1'b0, 10'd5, 16'h105);
        check("push full ignored head", 64'(stall_set), 64'h1);
        lookup_set = 10'd5; #1;
        check("hit set5 absent", 64'(stall_hit), 64'h0);
        push_pop(1'b1, 1'b1, 10'd5, 16'h105);
        check("pushpop full head", 64'(stall_set), 64'h2);
        check("pushpop full still full", 64'(stall_full), 64'h1);
        check("hit set5 stored", 64'(stall_hit), 64'(HIT_ON));
        lookup_set = 10'd1; #1;
        check("hit set1 popped", 64'(stall_hit), 64'h0);
        push_pop(1'b0, 1'b1, '0, '0);
        check("pop head3", 64'(stall_set), 64'h3);
        check("pop not full", 64'(stall_full), 64'h0);
        push_pop(1'b0, 1'b1, '0, '0);
        push_pop(1'b0, 1'b1, '0, '0);
        check("pop head5 set", 64'(stall_set), 64'h5);
        check("pop head5 tag", 64'(stall_tag), 64'h105);
        push_pop(1'b0, 1'b1, '0, '0);
        check("drained empty", 64'(stall_empty), 64'h1);
        check("drained head", 64'(stall_set), 64'h0);
        push_pop(1'b0, 1'b1, '0, '0);
        check("pop empty stays empty", 64'(stall_empty), 64'h1);
        push_pop(1'b1, 1'b1, 10'h2A, 16'hCAFE);
        check("pushpop empty not empty", 64'(stall_empty), 64'h0);
        check("pushpop empty head set", 64'(stall_set), 64'h2A);
        check("pushpop empty head tag", 64'(stall_tag), 64'hCAFE);

        way_next = 4'd3; tags_buf[3] = 16'hBEEF; cur_set = 10'h012; lookup_en = 1'b1;
        step();
        lookup_en = 1'b0;
        check("addr_evict", 64'(addr_evict), 64'({16'hBEEF, 10'h012}));
        tags_buf[3] = 16'h0000; cur_set = 10'h3FF; step();
        check("addr_evict holds", 64'(addr_evict), 64'({16'hBEEF, 10'h012}));

        flag_set = 8'hA5; sweep_incr = 1'b1; dma_load = 1'b1;
        dma_addr_in = 26'h0000100; dma_len_in = 8'd4; step();
        flag_set = '0; dma_load = 1'b0; dma_incr = 1'b1; step();
        check("pre soft dma_addr", 64'(dma_addr), 64'h101);
        rst_state = 1'b1; stall_push = 1'b1; stall_set_in = 10'h7; lookup_set = 10'h2A;
        step();
        rst_state = 1'b0; stall_push = 1'b0; sweep_incr = 1'b0; dma_incr = 1'b0;
        check_reset_state("soft_rst");
        check("soft_rst addr_evict held", 64'(addr_evict), 64'({16'hBEEF, 10'h012}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
